// File: rtl/pc_sequencer_if.sv
// Flow-control bundle between the control unit and the PC sequencer.
// Decodes flow in from the master; the PC, stack depth and error flags flow back.
interface pc_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic              en;
  logic              branch;
  logic              cond;
  logic              jump;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic              err_clr;

  logic [ADDR_W-1:0]  pc;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_overflow;
  logic               stack_underflow;

  modport master (
    output en, branch, cond, jump, call, ret, target, err_clr,
    input  pc, depth, stack_full, stack_overflow, stack_underflow
  );

  modport slave (
    input  en, branch, cond, jump, call, ret, target, err_clr,
    output pc, depth, stack_full, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with a bounded LIFO return-address stack and sticky
// overflow/underflow flags. Next PC priority: ret > call > jump > taken branch > pc+1.
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_PC    = 0
) (
  input logic          clk,
  input logic          rst_n,
  pc_sequencer_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0]  pc_inc;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;
  logic               push_en;
  logic               full;
  logic               empty;

  assign pc_inc   = pc_q + 1'b1;
  assign push_idx = depth_q[IDX_W-1:0];
  assign pop_idx  = push_idx - 1'b1;
  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == '0);

  // Error clear is applied first so a same-cycle set condition overrides it.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;

    if (bus.err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (bus.en) begin
      if (bus.ret) begin
        if (empty) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end else begin
          pc_d    = stack_q[pop_idx];
          depth_d = depth_q - 1'b1;
        end
      end else if (bus.call) begin
        if (full) begin
          pc_d  = pc_inc;
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          pc_d    = bus.target;
          depth_d = depth_q + 1'b1;
        end
      end else if (bus.jump) begin
        pc_d = bus.target;
      end else if (bus.branch && bus.cond) begin
        pc_d = bus.target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= ADDR_W'(RESET_PC);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign bus.pc              = pc_q;
  assign bus.depth           = depth_q;
  assign bus.stack_full      = full;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule
